// File: rtl/gb_timer.sv
// gb_timer: DMG DIV/TIMA/TMA/TAC timer block.
// Falling-edge TIMA clocking with delayed TMA reload and IRQ.
module gb_timer #(
    parameter int          RELOAD_DELAY = 4,
    parameter logic [15:0] BASE_ADDR    = 16'hFF04
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  data_out,
    input  logic        mem_wr,
    output logic [7:0]  rd_data,
    output logic        timer_irq,
    output logic [7:0]  div_out
);

    localparam int CW = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
    localparam logic [CW-1:0] RLD_INIT = CW'(RELOAD_DELAY - 1);

    typedef enum logic {
        IDLE,
        RELOADING
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] rcnt, rcnt_n;
    logic [15:0]   div_cnt, div_n;
    logic [7:0]    tima, tima_n;
    logic [7:0]    tma, tma_n;
    logic [2:0]    tac, tac_n;
    logic          tick_hist, tick_n;
    logic          tap;
    logic          inc;
    logic          reload;
    logic [7:0]    rd_n;

    logic sel_div, sel_tima, sel_tma, sel_tac;

    assign sel_div  = (mem_addr == BASE_ADDR);
    assign sel_tima = (mem_addr == BASE_ADDR + 16'd1);
    assign sel_tma  = (mem_addr == BASE_ADDR + 16'd2);
    assign sel_tac  = (mem_addr == BASE_ADDR + 16'd3);

    // Reload fires in the cycle the down-counter sits at zero
    assign reload    = (state == RELOADING) && (rcnt == '0);
    assign timer_irq = reload;
    assign div_out   = div_cnt[15:8];

    // Next-state: divider, tick edge detect, TIMA and reload sequencing
    always_comb begin
        div_n   = div_cnt + 16'd1;
        tac_n   = tac;
        tma_n   = tma;
        tima_n  = tima;
        state_n = state;
        rcnt_n  = rcnt;
        tap     = 1'b0;
        if (mem_wr && sel_div)
            div_n = '0;
        if (mem_wr && sel_tac)
            tac_n = data_out[2:0];
        if (mem_wr && sel_tma)
            tma_n = data_out;
        unique case (tac_n[1:0])
            2'b00: tap = div_n[9];
            2'b01: tap = div_n[3];
            2'b10: tap = div_n[5];
            2'b11: tap = div_n[7];
        endcase
        tick_n = tap & tac_n[2];
        inc    = tick_hist & ~tick_n;
        if (reload) begin
            tima_n  = tma_n;
            state_n = IDLE;
        end else begin
            if (state == RELOADING)
                rcnt_n = rcnt - CW'(1);
            if (mem_wr && sel_tima) begin
                tima_n  = data_out;
                state_n = IDLE;
            end else if (inc) begin
                tima_n = tima + 8'd1;
                if (tima == 8'hFF) begin
                    state_n = RELOADING;
                    rcnt_n  = RLD_INIT;
                end
            end
        end
    end

    // Read mux reflects the values being committed on this edge
    always_comb begin
        rd_n = 8'hFF;
        unique case (1'b1)
            sel_div:  rd_n = div_n[15:8];
            sel_tima: rd_n = tima_n;
            sel_tma:  rd_n = tma_n;
            sel_tac:  rd_n = {5'b11111, tac_n};
            default:  rd_n = 8'hFF;
        endcase
    end

    // State registers
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rcnt      <= '0;
            div_cnt   <= '0;
            tima      <= '0;
            tma       <= '0;
            tac       <= '0;
            tick_hist <= 1'b0;
            rd_data   <= 8'hFF;
        end else begin
            state     <= state_n;
            rcnt      <= rcnt_n;
            div_cnt   <= div_n;
            tima      <= tima_n;
            tma       <= tma_n;
            tac       <= tac_n;
            tick_hist <= tick_n;
            rd_data   <= rd_n;
        end
    end

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed bench for gb_timer.
// Each task drives a scenario and checks hand-computed values.
module tb_gb_timer;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  rd_data;
    logic        timer_irq;
    logic [7:0]  div_out;

    int total = 0;
    int bad = 0;
    int irq_count = 0;

    gb_timer dut (
        .Clk      (Clk),
        .reset_n  (reset_n),
        .mem_addr (mem_addr),
        .data_out (data_out),
        .mem_wr   (mem_wr),
        .rd_data  (rd_data),
        .timer_irq(timer_irq),
        .div_out  (div_out)
    );

    always #5 Clk = ~Clk;

    // Count irq cycles away from the active edge
    always @(negedge Clk)
        if (timer_irq === 1'b1) irq_count++;

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        mem_addr = a;
        data_out = d;
        mem_wr   = 1'b1;
        @(posedge Clk);
        #1;
        mem_wr   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Leaves div_cnt=15, TIMA=FF, TMA=tma_v, TAC=101, addr=TIMA
    task automatic setup_ovf(input logic [7:0] tma_v);
        wr(16'hFF07, 8'h00);
        wr(16'hFF04, 8'h00);
        wr(16'hFF06, tma_v);
        wr(16'hFF05, 8'hFF);
        wr(16'hFF07, 8'h05);
        mem_addr = 16'hFF05;
        step(12);
    endtask

    task automatic test_reset;
        #12;
        total++;
        if (rd_data !== 8'hFF) begin
            bad++;
            $display("FAIL reset_rd got=%h exp=ff", rd_data);
        end
        total++;
        if (timer_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", timer_irq);
        end
        total++;
        if (div_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_div got=%h exp=00", div_out);
        end
        @(posedge Clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_idle_run;
        mem_addr = 16'hFF04;
        step(1024);
        total++;
        if (rd_data !== 8'h04) begin
            bad++;
            $display("FAIL idle_div_rd got=%h exp=04", rd_data);
        end
        total++;
        if (div_out !== 8'h04) begin
            bad++;
            $display("FAIL idle_div_out got=%h exp=04", div_out);
        end
        mem_addr = 16'hFF05;
        step(1);
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL idle_tima got=%h exp=00", rd_data);
        end
        total++;
        if (irq_count !== 0) begin
            bad++;
            $display("FAIL idle_irq got=%0d exp=0", irq_count);
        end
    endtask

    task automatic test_tick_rate;
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'h00);
        mem_addr = 16'hFF05;
        step(13);
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL tick_pre got=%h exp=00", rd_data);
        end
        step(1);
        total++;
        if (rd_data !== 8'h01) begin
            bad++;
            $display("FAIL tick_first got=%h exp=01", rd_data);
        end
        step(240);
        total++;
        if (rd_data !== 8'h10) begin
            bad++;
            $display("FAIL tick_256 got=%h exp=10", rd_data);
        end
        total++;
        if (div_out !== 8'h01) begin
            bad++;
            $display("FAIL tick_div got=%h exp=01", div_out);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_t [5];
        logic       exp_i [5];
        int c0;
        exp_t = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAB};
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        c0 = irq_count;
        setup_ovf(8'hAB);
        total++;
        if (rd_data !== 8'hFF) begin
            bad++;
            $display("FAIL ovf_pre got=%h exp=ff", rd_data);
        end
        for (int i = 0; i < 5; i++) begin
            step(1);
            total++;
            if (rd_data !== exp_t[i]) begin
                bad++;
                $display("FAIL ovf_tima[%0d] got=%h exp=%h",
                         i, rd_data, exp_t[i]);
            end
            total++;
            if (timer_irq !== exp_i[i]) begin
                bad++;
                $display("FAIL ovf_irq[%0d] got=%b exp=%b",
                         i, timer_irq, exp_i[i]);
            end
        end
        total++;
        if (irq_count !== c0 + 1) begin
            bad++;
            $display("FAIL ovf_irq_cnt got=%0d exp=%0d",
                     irq_count, c0 + 1);
        end
    endtask

    task automatic test_tima_cancel;
        int c0;
        c0 = irq_count;
        setup_ovf(8'hAB);
        step(1);
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL cancel_ovf got=%h exp=00", rd_data);
        end
        step(1);
        wr(16'hFF05, 8'h55);
        total++;
        if (rd_data !== 8'h55) begin
            bad++;
            $display("FAIL cancel_wr got=%h exp=55", rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            total++;
            if (rd_data !== 8'h55 || timer_irq !== 1'b0) begin
                bad++;
                $display("FAIL cancel_hold[%0d] got=%h/%b exp=55/0",
                         i, rd_data, timer_irq);
            end
        end
        total++;
        if (irq_count !== c0) begin
            bad++;
            $display("FAIL cancel_irq_cnt got=%0d exp=%0d",
                     irq_count, c0);
        end
    endtask

    task automatic test_reload_write;
        int c0;
        c0 = irq_count;
        setup_ovf(8'hAB);
        step(4);
        total++;
        if (timer_irq !== 1'b1) begin
            bad++;
            $display("FAIL rlw_irq got=%b exp=1", timer_irq);
        end
        wr(16'hFF06, 8'h3C);
        total++;
        if (rd_data !== 8'h3C) begin
            bad++;
            $display("FAIL rlw_tma got=%h exp=3c", rd_data);
        end
        mem_addr = 16'hFF05;
        step(1);
        total++;
        if (rd_data !== 8'h3C) begin
            bad++;
            $display("FAIL rlw_tima_tma got=%h exp=3c", rd_data);
        end
        setup_ovf(8'hAB);
        step(4);
        wr(16'hFF05, 8'h99);
        total++;
        if (rd_data !== 8'hAB) begin
            bad++;
            $display("FAIL rlw_tima_ign got=%h exp=ab", rd_data);
        end
        total++;
        if (irq_count !== c0 + 2) begin
            bad++;
            $display("FAIL rlw_irq_cnt got=%0d exp=%0d",
                     irq_count, c0 + 2);
        end
    endtask

    task automatic test_div_glitch;
        wr(16'hFF07, 8'h00);
        wr(16'hFF04, 8'h00);
        wr(16'hFF05, 8'h20);
        wr(16'hFF07, 8'h05);
        step(6);
        wr(16'hFF04, 8'hA5);
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL glitch_div got=%h exp=00", rd_data);
        end
        mem_addr = 16'hFF05;
        step(1);
        total++;
        if (rd_data !== 8'h21) begin
            bad++;
            $display("FAIL glitch_inc got=%h exp=21", rd_data);
        end
        wr(16'hFF07, 8'h04);
        step(6);
        wr(16'hFF04, 8'h00);
        mem_addr = 16'hFF05;
        step(1);
        total++;
        if (rd_data !== 8'h21) begin
            bad++;
            $display("FAIL glitch_noinc got=%h exp=21", rd_data);
        end
        wr(16'hFF07, 8'h05);
        step(6);
        wr(16'hFF07, 8'h00);
        total++;
        if (rd_data !== 8'hF8) begin
            bad++;
            $display("FAIL glitch_tac_rd got=%h exp=f8", rd_data);
        end
        mem_addr = 16'hFF05;
        step(1);
        total++;
        if (rd_data !== 8'h22) begin
            bad++;
            $display("FAIL glitch_tac_inc got=%h exp=22", rd_data);
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        c0 = irq_count;
        setup_ovf(8'hAB);
        step(3);
        reset_n = 1'b0;
        #1;
        total++;
        if (timer_irq !== 1'b0 || rd_data !== 8'hFF || div_out !== 8'h00)
        begin
            bad++;
            $display("FAIL rst_mid got=%b/%h/%h exp=0/ff/00",
                     timer_irq, rd_data, div_out);
        end
        step(2);
        reset_n = 1'b1;
        mem_addr = 16'hFF07;
        step(1);
        total++;
        if (rd_data !== 8'hF8) begin
            bad++;
            $display("FAIL rst_tac got=%h exp=f8", rd_data);
        end
        mem_addr = 16'hFF03;
        step(1);
        total++;
        if (rd_data !== 8'hFF) begin
            bad++;
            $display("FAIL rst_ff03 got=%h exp=ff", rd_data);
        end
        mem_addr = 16'hFF05;
        step(1);
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL rst_tima got=%h exp=00", rd_data);
        end
        mem_addr = 16'hFF06;
        step(1);
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL rst_tma got=%h exp=00", rd_data);
        end
        total++;
        if (irq_count !== c0) begin
            bad++;
            $display("FAIL rst_irq_cnt got=%0d exp=%0d", irq_count, c0);
        end
        wr(16'hFF08, 8'h07);
        wr(16'hFF03, 8'h07);
        total++;
        if (rd_data !== 8'hFF) begin
            bad++;
            $display("FAIL unmap_wr_rd got=%h exp=ff", rd_data);
        end
        mem_addr = 16'hFF07;
        step(1);
        total++;
        if (rd_data !== 8'hF8) begin
            bad++;
            $display("FAIL unmap_tac got=%h exp=f8", rd_data);
        end
        mem_addr = 16'hFF08;
        step(1);
        total++;
        if (rd_data !== 8'hFF) begin
            bad++;
            $display("FAIL unmap_ff08 got=%h exp=ff", rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_idle_run();
        test_tick_rate();
        test_overflow();
        test_tima_cancel();
        test_reload_write();
        test_div_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_timer.md
Name: gb_timer

Overview:
- DMG timer/divider peripheral on the CPU memory bus, at FF04–FF07 (DIV, TIMA, TMA, TAC).
- Consumes CPU bus writes and reads. Produces read data back to the CPU data_in mux and a timer interrupt request to the interrupt-flag logic (IF bit 2).
- Clk advances one T-cycle per rising edge, i.e. it is driven from the same CPU clock domain as the cpu core.

Parameters:
- RELOAD_DELAY, 4: cycles between TIMA overflow and the TMA reload / IRQ.
- BASE_ADDR, 16'hFF04: address of DIV; TIMA, TMA and TAC follow at +1, +2, +3.

Ports:
- Clk  in  1  CPU T-cycle clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  in  16  CPU bus address.
- data_out  in  8  CPU write data, i.e. the CPU's data_out.
- mem_wr  in  1  write strobe, one cycle per write.
- rd_data  out  8  registered read data for mem_addr; 8'hFF when the address is not decoded.
- timer_irq  out  1  one-cycle pulse requesting IF bit 2.
- div_out  out  8  DIV value for debug / APU frame sequencer.

Behaviour:
- Reset is asynchronous and active-low:
  - div_cnt[15:0]=0, TIMA=0, TMA=0, TAC[2:0]=0.
  - Reload state IDLE, falling-edge history reg=0.
  - rd_data=8'hFF, timer_irq=0, div_out=0.
- div_cnt increments by 1 every cycle and wraps FFFF->0000. DIV reads div_cnt[15:8]; div_out mirrors div_cnt[15:8].
- Any write to DIV clears div_cnt to 0 on that edge, ignoring the data value.
- Tap bit selected by TAC[1:0]:
  - 00 -> div_cnt[9]
  - 01 -> div_cnt[3]
  - 10 -> div_cnt[5]
  - 11 -> div_cnt[7]
- tick_sig = tap & TAC[2]. A registered history of tick_sig is kept.
- TIMA increments on the cycle where history=1 and the new tick_sig=0 (falling edge).
- Because of this, a DIV write or TAC write that drops tick_sig from 1 to 0 also increments TIMA. This DMG glitch behaviour is required.
- Overflow: an increment at TIMA=FF makes TIMA=00 and enters the RELOADING state with a down-counter set to RELOAD_DELAY-1.
- RELOADING:
  - TIMA reads 00 and increments continue normally.
  - When the counter reaches 0: TIMA<=TMA, timer_irq=1 for exactly that one cycle, state->IDLE.
- Write to TIMA while in RELOADING and before the reload cycle: the write is stored, and both the reload and the IRQ are cancelled.
- Write to TIMA on the reload cycle itself: the write is ignored; TMA is loaded.
- Write to TMA on the reload cycle: the new TMA value is the one loaded into TIMA.
- Write to TIMA coinciding with an increment: the write wins.
- TAC writes store data[2:0]. TAC reads return {5'b11111, TAC}.
- Read path: rd_data is registered and reflects mem_addr sampled on the previous edge. It returns the post-update register value of that cycle. Latency is 1 cycle. Undecoded addresses return FF.
- Writes to FF08+ or below BASE_ADDR are ignored. No address aliasing.
- Reset asserted mid-reload aborts the reload and suppresses any IRQ; timer_irq drops immediately.

Test Plan:
- Reset, then run 1024 cycles with no writes -> DIV reads 8'h04; TIMA=0; timer_irq never asserts.
- TAC=3'b101 (bit 3, enabled), TIMA=0 -> TIMA=1 after 16 cycles from a div_cnt multiple of 16; TIMA=8'h10 after 256 cycles.
- TMA=8'hAB, TIMA=8'hFF, TAC=3'b101 -> at the overflow tick TIMA=00 for 4 cycles, then TIMA=AB with a single-cycle timer_irq on the 4th cycle.
- Same setup, but write TIMA=8'h55 two cycles after overflow -> TIMA=55, no reload, timer_irq stays 0.
- TAC=3'b101 with div_cnt[3]=1, then write DIV -> div_cnt=0 and TIMA increments by exactly 1 on that edge. Repeat with TAC=3'b100 -> no increment.
- Assert reset_n=0 one cycle before the reload cycle -> all registers return to reset values, no irq pulse; TAC reads 8'hF8 and an unmapped address (FF03) reads 8'hFF.
